// File: rtl/seg7_scan_mux_if.sv
// Bus bundle between a value source and the seg7_scan_mux display driver.
// With SEG7_SCAN_DIM_EN defined the bundle also carries the 3-bit brightness control.
interface seg7_scan_mux_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lzb_en;
`ifdef SEG7_SCAN_DIM_EN
  logic [2:0]  brightness;
`endif
  logic [6:0]  segments;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic        pending;

`ifdef SEG7_SCAN_DIM_EN
  modport master (
    output value_in, dp_in, load, lzb_en, brightness,
    input  segments, dp_out, digit_en, frame_start, pending
  );
  modport slave (
    input  value_in, dp_in, load, lzb_en, brightness,
    output segments, dp_out, digit_en, frame_start, pending
  );
`else
  modport master (
    output value_in, dp_in, load, lzb_en,
    input  segments, dp_out, digit_en, frame_start, pending
  );
  modport slave (
    input  value_in, dp_in, load, lzb_en,
    output segments, dp_out, digit_en, frame_start, pending
  );
`endif
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with frame-aligned (tear-free) value updates.
// Optional PWM dimming is compiled in when the macro SEG7_SCAN_DIM_EN is defined.
module seg7_scan_mux #(
  parameter int TICK_DIV     = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_mux_if.slave  bus
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow_val;
  logic [3:0]       r_shadow_dp;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  logic             r_pending;
  logic             r_frame_start;
  logic             r_active;

  logic             w_slot_end;
  logic             w_wrap;
  logic             w_show;
  logic             w_en_gate;
  logic [3:0]       w_nibble;
  logic [6:0]       w_decoded;
  logic [3:0]       w_blank;
  logic             w_lzb_off;

  assign w_slot_end = (r_cnt == CNT_MAX);
  assign w_wrap     = w_slot_end && (r_idx == 2'd3);
  assign w_show     = (r_cnt >= CNT_BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A load on the wrap edge bypasses the pending slot and wins over it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pending    <= 1'b0;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (bus.load) begin
        r_shadow_val <= bus.value_in;
        r_shadow_dp  <= bus.dp_in;
      end else if (r_pending) begin
        r_shadow_val <= r_pend_val;
        r_shadow_dp  <= r_pend_dp;
      end
    end else if (bus.load) begin
      r_pend_val <= bus.value_in;
      r_pend_dp  <= bus.dp_in;
      r_pending  <= 1'b1;
    end
  end

  // r_active keeps segments dark while reset is held, even though shadow 0 decodes to "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      r_active      <= 1'b1;
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  logic [2:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 3'd1;
    end
  end

  assign w_en_gate = (r_pwm <= bus.brightness);
`else
  assign w_en_gate = 1'b1;
`endif

  assign w_nibble = r_shadow_val[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_decoded = 7'h00;
    case (w_nibble)
      4'h0: w_decoded = 7'h3F;
      4'h1: w_decoded = 7'h06;
      4'h2: w_decoded = 7'h5B;
      4'h3: w_decoded = 7'h4F;
      4'h4: w_decoded = 7'h66;
      4'h5: w_decoded = 7'h6D;
      4'h6: w_decoded = 7'h7D;
      4'h7: w_decoded = 7'h07;
      4'h8: w_decoded = 7'h7F;
      4'h9: w_decoded = 7'h6F;
      4'hA: w_decoded = 7'h77;
      4'hB: w_decoded = 7'h7C;
      4'hC: w_decoded = 7'h39;
      4'hD: w_decoded = 7'h5E;
      4'hE: w_decoded = 7'h79;
      4'hF: w_decoded = 7'h71;
      default: w_decoded = 7'h00;
    endcase
  end

  // Blank chain runs from the top digit down; digit 0 always shows.
  assign w_blank[3] = (r_shadow_val[15:12] == 4'h0);
  assign w_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 3; gi++) begin : g_blank
    assign w_blank[gi] = w_blank[gi+1] && (r_shadow_val[gi*4 +: 4] == 4'h0);
  end

  assign w_lzb_off = bus.lzb_en && w_blank[r_idx];

  assign bus.segments    = (r_active && !w_lzb_off) ? w_decoded : 7'h00;
  assign bus.dp_out      = r_active && r_shadow_dp[r_idx];
  assign bus.digit_en    = (w_show && w_en_gate) ? (4'b0001 << r_idx) : 4'b0000;
  assign bus.frame_start = r_frame_start;
  assign bus.pending     = r_pending;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (TICK_DIV=8, BLANK_CYCLES=2) using a per-slot scoreboard.
// Dimming scenario is compiled only when SEG7_SCAN_DIM_EN is defined.
module tb_seg7_scan_mux;
  localparam int TD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_mux_if bus();

  seg7_scan_mux #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h3F; 4'h1: r = 7'h06; 4'h2: r = 7'h5B; 4'h3: r = 7'h4F;
      4'h4: r = 7'h66; 4'h5: r = 7'h6D; 4'h6: r = 7'h7D; 4'h7: r = 7'h07;
      4'h8: r = 7'h7F; 4'h9: r = 7'h6F; 4'hA: r = 7'h77; 4'hB: r = 7'h7C;
      4'hC: r = 7'h39; 4'hD: r = 7'h5E; 4'hE: r = 7'h79; default: r = 7'h71;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic lzb);
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.seg = (lzb && d > 0 && (v >> (4 * d)) == 16'd0) ? 7'h00 : hex7(v[4*d +: 4]);
      e.dp  = dp[d];
      e.en  = 4'(1 << d);
      sb.push_back(e);
      $display("[TB] expect slot %0d seg=%h dp=%b", d, e.seg, e.dp);
    end
  endtask

  task automatic check_pending(input string name, input logic exp);
    n_tests++;
    if (bus.pending !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s pending got=%b want=%b", name, bus.pending, exp);
    end
  endtask

  task automatic wait_frame_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.frame_start === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s frame_start got=timeout want=pulse", name);
    end
  endtask

  // Entered at the frame_start sample; leaves at the next frame_start sample.
  task automatic check_frame(input string name);
    exp_t e;
    n_tests++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s frame_start got=%b want=1", name, bus.frame_start);
    end
    for (int c = 0; c < 4 * TD; c++) begin
      if (c > 0) tick();
      if (c % TD == 0) begin
        n_tests++;
        if (bus.digit_en !== 4'b0000) begin
          n_fail++;
          $display("[TB] FAIL %s blank_en slot%0d got=%b want=0000", name, c / TD, bus.digit_en);
        end
      end
      if (c % TD == BC + 2) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL %s scoreboard got=empty want=entry", name);
        end else begin
          e = sb.pop_front();
          if (bus.segments !== e.seg || bus.dp_out !== e.dp || bus.digit_en !== e.en) begin
            n_fail++;
            $display("[TB] FAIL %s slot%0d got seg=%h dp=%b en=%b want seg=%h dp=%b en=%b",
                     name, c / TD, bus.segments, bus.dp_out, bus.digit_en, e.seg, e.dp, e.en);
          end else begin
            $display("[TB] %s slot%0d seg=%h dp=%b en=%b ok", name, c / TD,
                     bus.segments, bus.dp_out, bus.digit_en);
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.segments !== 7'h00 || bus.dp_out !== 1'b0 || bus.digit_en !== 4'b0000 ||
        bus.frame_start !== 1'b0 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset got seg=%h dp=%b en=%b fs=%b pend=%b want all 0",
               bus.segments, bus.dp_out, bus.digit_en, bus.frame_start, bus.pending);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int cnt;
    int idx;
    logic [3:0] exp_en;
    logic exp_fs;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) tick();
      cnt    = k % TD;
      idx    = (k / TD) % 4;
      exp_en = (cnt >= BC) ? 4'(1 << idx) : 4'b0000;
      exp_fs = (k == 32);
      n_tests++;
      if (bus.digit_en !== exp_en || bus.frame_start !== exp_fs) begin
        n_fail++;
        $display("[TB] FAIL scan k=%0d got en=%b fs=%b want en=%b fs=%b",
                 k, bus.digit_en, bus.frame_start, exp_en, exp_fs);
      end
    end
    $display("[TB] scan 34 cycles checked");
  endtask

  task automatic test_decode();
    do_load(16'hA8F1, 4'b0100);
    check_pending("decode_load", 1'b1);
    push_frame(16'hA8F1, 4'b0100, 1'b0);
    wait_frame_start("decode_wait");
    check_pending("decode_applied", 1'b0);
    check_frame("decode");
  endtask

  task automatic test_lzb();
    bus.lzb_en = 1'b1;
    do_load(16'h0050, 4'b0000);
    push_frame(16'h0050, 4'b0000, 1'b1);
    wait_frame_start("lzb_wait");
    check_frame("lzb_on");
    bus.lzb_en = 1'b0;
    push_frame(16'h0050, 4'b0000, 1'b0);
    check_frame("lzb_off");
  endtask

  task automatic test_tear_free();
    for (int i = 0; i < 10; i++) tick();
    do_load(16'h1111, 4'b0000);
    check_pending("tear_first", 1'b1);
    for (int i = 0; i < 5; i++) tick();
    do_load(16'h2222, 4'b0000);
    for (int i = 0; i < 11; i++) tick();
    n_tests++;
    if (bus.segments !== 7'h3F || bus.digit_en !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL tear_old got seg=%h en=%b want seg=3f en=1000", bus.segments, bus.digit_en);
    end
    for (int i = 0; i < 3; i++) tick();
    check_pending("tear_hold", 1'b1);
    push_frame(16'h2222, 4'b0000, 1'b0);
    wait_frame_start("tear_wait");
    check_pending("tear_applied", 1'b0);
    check_frame("tear_new");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) tick();
    do_load(16'h4444, 4'b0000);
    check_pending("simul_older", 1'b1);
    for (int i = 0; i < 25; i++) tick();
    do_load(16'h3333, 4'b1111);
    check_pending("simul_wrap", 1'b0);
    push_frame(16'h3333, 4'b1111, 1'b0);
    check_frame("simul");
  endtask

  task automatic test_async_reset();
    tick();
    do_load(16'h5555, 4'b0000);
    tick();
    tick();
    n_tests++;
    if (bus.digit_en !== 4'b0001 || bus.dp_out !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL areset_pre got en=%b dp=%b want en=0001 dp=1", bus.digit_en, bus.dp_out);
    end
    check_pending("areset_pre", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.segments !== 7'h00 || bus.dp_out !== 1'b0 || bus.digit_en !== 4'b0000 ||
        bus.frame_start !== 1'b0 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset got seg=%h dp=%b en=%b fs=%b pend=%b want all 0",
               bus.segments, bus.dp_out, bus.digit_en, bus.frame_start, bus.pending);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_frame_start("areset_wait");
    check_pending("areset_discard", 1'b0);
    check_frame("areset_frame");
  endtask

`ifdef SEG7_SCAN_DIM_EN
  task automatic test_dimming(input logic [2:0] br);
    int cnt;
    int idx;
    logic [3:0] exp_en;
    bus.brightness = br;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      cnt    = k % TD;
      idx    = (k / TD) % 4;
      exp_en = (cnt >= BC && (k % 8) <= int'(br)) ? 4'(1 << idx) : 4'b0000;
      n_tests++;
      if (bus.digit_en !== exp_en) begin
        n_fail++;
        $display("[TB] FAIL dim br=%0d k=%0d got en=%b want en=%b", br, k, bus.digit_en, exp_en);
      end
    end
    $display("[TB] dimming br=%0d checked", br);
    bus.brightness = 3'd7;
  endtask
`endif

  initial begin
    bus.value_in = 16'h0000;
    bus.dp_in    = 4'b0000;
    bus.load     = 1'b0;
    bus.lzb_en   = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
    bus.brightness = 3'd7;
`endif
    test_reset();
    test_scan();
    test_decode();
    test_lzb();
    test_tear_free();
    test_back_to_back();
    test_async_reset();
`ifdef SEG7_SCAN_DIM_EN
    test_dimming(3'd0);
    test_dimming(3'd3);
`endif
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
